// File: rtl/friscv_regfile_sb_if.sv
// Register-file bus between issue/write-back (master) and the register file (slave).
// Read, lock and write-back channels are flat vectors, one slice per port.
interface friscv_regfile_sb_if #(
    parameter int XLEN        = 32,
    parameter int NB_RD_PORTS = 4,
    parameter int NB_WR_PORTS = 2
);
    logic [NB_RD_PORTS*5-1:0]      rd_addr;
    logic [NB_RD_PORTS*XLEN-1:0]   rd_val;
    logic [NB_RD_PORTS-1:0]        rd_busy;
    logic                          lock_valid;
    logic [4:0]                    lock_addr;
    logic                          lock_ready;
    logic [NB_WR_PORTS-1:0]        wr_en;
    logic [NB_WR_PORTS*5-1:0]      wr_addr;
    logic [NB_WR_PORTS*XLEN-1:0]   wr_val;
    logic [NB_WR_PORTS*XLEN/8-1:0] wr_strb;
    logic                          sb_error;

    modport master (
        output rd_addr, lock_valid, lock_addr, wr_en, wr_addr, wr_val, wr_strb,
        input  rd_val, rd_busy, lock_ready, sb_error
    );

    modport slave (
        input  rd_addr, lock_valid, lock_addr, wr_en, wr_addr, wr_val, wr_strb,
        output rd_val, rd_busy, lock_ready, sb_error
    );
endinterface

// File: rtl/friscv_regfile_sb.sv
// ISA register file with a per-register pending-write counter (scoreboard).
// Issue locks rd at dispatch, write-back releases it; rd_busy tells issue to stall.
module friscv_regfile_sb #(
    parameter int XLEN        = 32,
    parameter int RV32E       = 0,
    parameter int NB_RD_PORTS = 4,
    parameter int NB_WR_PORTS = 2,
    parameter int BYPASS      = 1,
    parameter int PEND_W      = 2
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic srst,
    friscv_regfile_sb_if.slave bus
);

    localparam int NB = XLEN / 8;
    // wide enough for cnt + 1 lock and for the release count of every write port
    localparam int CW = PEND_W + $clog2(NB_WR_PORTS + 1) + 1;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]   regs     [32];
    logic [PEND_W-1:0] cnt      [32];
    logic [XLEN-1:0]   merged   [32];
    logic [CW-1:0]     rel      [32];
    logic [PEND_W-1:0] cnt_nxt  [32];
    logic [PEND_W-1:0] cnt_rel  [32];
    logic [31:0]       underflow;
    logic              lock_legal;
    logic              lock_fire;
    logic              err_set;
    logic              sb_error_q;
    logic [NB_RD_PORTS*XLEN-1:0] rd_val_c;
    logic [NB_RD_PORTS-1:0]      rd_busy_c;

    // Registers 16..31 do not exist in the embedded variant.
    function automatic logic legal(input logic [4:0] a);
        return !((RV32E != 0) && a[4]);
    endfunction

    // Byte merge of all write-back ports onto each register; loop runs high-to-low so
    // the lowest-index port is applied last and wins each byte. Also counts releases.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            merged[r] = regs[r];
            rel[r]    = '0;
            for (int p = NB_WR_PORTS - 1; p >= 0; p--) begin
                if (bus.wr_en[p] && bus.wr_addr[p*5 +: 5] == 5'(r)) begin
                    rel[r] = rel[r] + CW'(1);
                    for (int b = 0; b < NB; b++) begin
                        if (bus.wr_strb[p*NB + b])
                            merged[r][b*8 +: 8] = bus.wr_val[p*XLEN + b*8 +: 8];
                    end
                end
            end
        end
    end

    // Lock is refused only when the counter is saturated and nothing frees a slot now.
    always_comb begin
        lock_legal     = legal(bus.lock_addr) && (bus.lock_addr != 5'd0);
        bus.lock_ready = !(lock_legal && cnt[bus.lock_addr] == CNT_MAX
                           && rel[bus.lock_addr] == '0);
        lock_fire      = bus.lock_valid && bus.lock_ready;
    end

    // Next counter values; a release with nothing outstanding clamps at zero and flags.
    always_comb begin
        logic [CW-1:0] sum;
        sum       = '0;
        underflow = '0;
        for (int r = 0; r < 32; r++) begin
            cnt_nxt[r] = '0;
            cnt_rel[r] = '0;
            if (r != 0 && legal(5'(r))) begin
                sum = CW'(cnt[r]) + CW'(lock_fire && lock_legal && bus.lock_addr == 5'(r));
                if (rel[r] > sum)
                    underflow[r] = 1'b1;
                else
                    cnt_nxt[r] = PEND_W'(sum - rel[r]);
                // busy view: releases applied, same-cycle lock deliberately ignored
                if (rel[r] < CW'(cnt[r]))
                    cnt_rel[r] = PEND_W'(CW'(cnt[r]) - rel[r]);
            end
        end
    end

    // Error sources: scoreboard underflow or any enabled access to a missing register.
    always_comb begin
        err_set = (|underflow) || (lock_fire && !legal(bus.lock_addr));
        for (int p = 0; p < NB_WR_PORTS; p++) begin
            if (bus.wr_en[p] && !legal(bus.wr_addr[p*5 +: 5]))
                err_set = 1'b1;
        end
    end

    // Read ports: x0 and missing registers read zero and are never busy.
    always_comb begin
        logic [4:0] a;
        rd_val_c  = '0;
        rd_busy_c = '0;
        for (int p = 0; p < NB_RD_PORTS; p++) begin
            a = bus.rd_addr[p*5 +: 5];
            if (legal(a) && a != 5'd0) begin
                rd_val_c[p*XLEN +: XLEN] = (BYPASS != 0) ? merged[a] : regs[a];
                rd_busy_c[p]             = (cnt_rel[a] != '0);
            end
        end
    end

    assign bus.rd_val   = rd_val_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.sb_error = sb_error_q;

    // State update: storage, scoreboard counters and the sticky error flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int r = 0; r < 32; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_error_q <= 1'b0;
        end else if (srst) begin
            for (int r = 0; r < 32; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_error_q <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (r != 0 && legal(5'(r)))
                    regs[r] <= merged[r];
                cnt[r] <= cnt_nxt[r];
            end
            sb_error_q <= sb_error_q || err_set;
        end
    end

endmodule
